// File: rtl/fe_pkg.sv
// Shared widths, bundle layout and helpers for the front-end uop queue.
package fe_pkg;

  localparam int unsigned FE_UOP_W = 20;
  localparam int unsigned FE_UOPS  = 3;
  localparam int unsigned FE_K_W   = 16;
  localparam int unsigned FE_CNT_W = $clog2(FE_UOPS + 1);

  // One decoded bundle at the default widths.
  typedef struct packed {
    logic [FE_UOPS*FE_UOP_W-1:0] uops;
    logic [FE_CNT_W-1:0]         count;
    logic [FE_K_W-1:0]           k;
  } fe_bundle_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned fe_lowest_set(input logic [31:0] v);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fe_irq_arbiter.sv
// Fixed-priority interrupt pick behind a single mask; line 0 wins.
module fe_irq_arbiter
  import fe_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  localparam int unsigned VEC_W  = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               a_rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               int_restore,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [VEC_W-1:0]   irq_vec
);

  logic               mask_q, mask_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_IRQ-1:0] pend;
  logic [VEC_W-1:0]   sel;
  logic               take;

  assign pend    = irq & {NUM_IRQ{~mask_q}};
  assign sel     = VEC_W'(fe_lowest_set(32'(pend)));
  assign take    = ~int_restore & (|pend);
  assign irq_ack = take ? (NUM_IRQ'(1) << sel) : '0;
  assign irq_vec = vec_q;

  // Restore has priority; an acknowledge sets the mask until restore.
  always_comb begin
    mask_d = mask_q;
    vec_d  = vec_q;
    if (int_restore) begin
      mask_d = 1'b0;
    end else if (take) begin
      mask_d = 1'b1;
      vec_d  = sel;
    end
  end

  // Mask and last-vector registers.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      mask_q <= 1'b0;
      vec_q  <= '0;
    end else begin
      mask_q <= mask_d;
      vec_q  <= vec_d;
    end
  end

endmodule

// File: rtl/fe_uop_queue.sv
// Decode-to-execute bundle FIFO with PC-redirect flush and interrupt arbitration.
module fe_uop_queue
  import fe_pkg::*;
#(
  parameter int unsigned UOP_W   = FE_UOP_W,
  parameter int unsigned UOPS    = FE_UOPS,
  parameter int unsigned K_W     = FE_K_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_IRQ = 4,
  localparam int unsigned CNT_W  = $clog2(UOPS + 1),
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1),
  localparam int unsigned VEC_W  = $clog2(NUM_IRQ)
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  de_valid,
  output logic                  de_ready,
  input  logic [UOP_W*UOPS-1:0] de_uops,
  input  logic [CNT_W-1:0]      de_uop_count,
  input  logic [K_W-1:0]        de_k,
  input  logic                  ex_pc_w,
  input  logic                  ex_feed_req,
  output logic                  ex_feed_ack,
  output logic [UOP_W*UOPS-1:0] ex_uops,
  output logic [CNT_W-1:0]      ex_uop_count,
  output logic [K_W-1:0]        ex_k,
  output logic [LVL_W-1:0]      q_level,
  input  logic [NUM_IRQ-1:0]    irq,
  output logic [NUM_IRQ-1:0]    irq_ack,
  output logic [VEC_W-1:0]      irq_vec,
  input  logic                  int_restore
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = UOP_W*UOPS + CNT_W + K_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             enq, pop, not_empty;
  logic [ENT_W-1:0] head;

  assign not_empty    = (level_q != '0);
  assign de_ready     = (level_q != LVL_W'(DEPTH));
  assign enq          = de_valid & de_ready & ~ex_pc_w & (de_uop_count != '0);
  assign pop          = ex_feed_req & not_empty & ~ex_pc_w;
  assign ex_feed_ack  = pop;
  assign q_level      = level_q;

  assign head         = mem_q[rd_ptr_q];
  assign ex_uops      = head[ENT_W-1 -: UOP_W*UOPS];
  assign ex_uop_count = not_empty ? head[K_W +: CNT_W] : '0;
  assign ex_k         = head[K_W-1:0];

  // Pointer/level next state; a redirect empties the queue without touching storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (ex_pc_w) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(enq) - LVL_W'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Bundle storage, written only on accepted non-empty bundles.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {de_uops, de_uop_count, de_k};
  end

  fe_irq_arbiter #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq (
    .clk         (clk),
    .a_rst       (a_rst),
    .irq         (irq),
    .int_restore (int_restore),
    .irq_ack     (irq_ack),
    .irq_vec     (irq_vec)
  );

endmodule

// File: tb/tb_fe_uop_queue.sv
// Bench for fe_uop_queue: vector table, interrupt sequences, reset, random run vs queue model.
module tb_fe_uop_queue;
  import fe_pkg::*;

  localparam int unsigned UW  = FE_UOP_W;
  localparam int unsigned NU  = FE_UOPS;
  localparam int unsigned KW  = FE_K_W;
  localparam int unsigned CW  = FE_CNT_W;
  localparam int unsigned DEP = 4;
  localparam int unsigned NI  = 4;

  logic          clk = 1'b0;
  logic          a_rst;
  logic          de_valid, de_ready;
  logic [UW*NU-1:0] de_uops, ex_uops;
  logic [CW-1:0] de_uop_count, ex_uop_count;
  logic [KW-1:0] de_k, ex_k;
  logic          ex_pc_w, ex_feed_req, ex_feed_ack;
  logic [2:0]    q_level;
  logic [NI-1:0] irq, irq_ack;
  logic [1:0]    irq_vec;
  logic          int_restore;

  always #5 clk = ~clk;

  fe_uop_queue #(
    .UOP_W   (UW),
    .UOPS    (NU),
    .K_W     (KW),
    .DEPTH   (DEP),
    .NUM_IRQ (NI)
  ) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .de_valid     (de_valid),
    .de_ready     (de_ready),
    .de_uops      (de_uops),
    .de_uop_count (de_uop_count),
    .de_k         (de_k),
    .ex_pc_w      (ex_pc_w),
    .ex_feed_req  (ex_feed_req),
    .ex_feed_ack  (ex_feed_ack),
    .ex_uops      (ex_uops),
    .ex_uop_count (ex_uop_count),
    .ex_k         (ex_k),
    .q_level      (q_level),
    .irq          (irq),
    .irq_ack      (irq_ack),
    .irq_vec      (irq_vec),
    .int_restore  (int_restore)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of bundles plus mask/vector state.
  fe_bundle_t  mq[$];
  bit          mmask;
  int unsigned mvec;
  bit          m_push, m_pop, m_flush, m_take, m_restore;
  fe_bundle_t  m_in;
  logic [NI-1:0] m_ack;

  // Compare DUT against the model at the falling edge and latch what the edge will do.
  task automatic tick_begin();
    logic [NI-1:0] p;
    @(negedge clk);
    m_flush   = ex_pc_w;
    m_pop     = ex_feed_req && mq.size() != 0 && !ex_pc_w;
    m_push    = de_valid && mq.size() != DEP && !ex_pc_w && de_uop_count != 0;
    m_in      = '{uops: de_uops, count: de_uop_count, k: de_k};
    m_restore = int_restore;
    p         = mmask ? '0 : irq;
    m_ack     = (int_restore || p == 0) ? '0 : (p & (~p + 1'b1));
    m_take    = (m_ack != 0);
    check("de_ready", de_ready, mq.size() != DEP);
    check("q_level", q_level, mq.size());
    check("lvl_range", q_level <= DEP, 1);
    check("ex_feed_ack", ex_feed_ack, m_pop);
    check("ex_uop_count", ex_uop_count, mq.size() != 0 ? mq[0].count : 0);
    if (mq.size() != 0) begin
      check("ex_k", ex_k, mq[0].k);
      check("ex_uops", ex_uops, mq[0].uops);
    end
    check("irq_ack", irq_ack, m_ack);
    check("irq_vec", irq_vec, mvec);
  endtask

  task automatic tick_end();
    @(posedge clk);
    if (m_flush) mq.delete();
    else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_in);
    end
    if (m_restore) mmask = 1'b0;
    else if (m_take) begin
      mmask = 1'b1;
      mvec  = $clog2(m_ack);
    end
    #1;
  endtask

  typedef struct {
    bit v; int unsigned c; logic [15:0] k; bit req; bit pcw;
    int unsigned lvl; bit rdy; bit ack; int unsigned cnt; logic [15:0] ek;
  } row_t;

  row_t rows[21];

  initial begin
    // Directed vectors: inputs | expected outputs before the edge.
    rows[0]  = '{1, 1, 16'h1000, 0, 0, 0, 1, 0, 0, 16'h0000};
    rows[1]  = '{1, 2, 16'h1001, 0, 0, 1, 1, 0, 1, 16'h1000};
    rows[2]  = '{1, 3, 16'h1002, 0, 0, 2, 1, 0, 1, 16'h1000};
    rows[3]  = '{0, 1, 16'h0000, 0, 0, 3, 1, 0, 1, 16'h1000};
    rows[4]  = '{1, 1, 16'h1003, 0, 0, 3, 1, 0, 1, 16'h1000};
    rows[5]  = '{1, 2, 16'h1004, 1, 0, 4, 0, 1, 1, 16'h1000};
    rows[6]  = '{1, 2, 16'h1004, 0, 0, 3, 1, 0, 2, 16'h1001};
    rows[7]  = '{0, 1, 16'h0000, 1, 0, 4, 0, 1, 2, 16'h1001};
    rows[8]  = '{0, 1, 16'h0000, 1, 0, 3, 1, 1, 3, 16'h1002};
    rows[9]  = '{0, 1, 16'h0000, 1, 0, 2, 1, 1, 1, 16'h1003};
    rows[10] = '{0, 1, 16'h0000, 1, 0, 1, 1, 1, 2, 16'h1004};
    rows[11] = '{1, 1, 16'h2000, 0, 0, 0, 1, 0, 0, 16'h0000};
    rows[12] = '{1, 2, 16'h2001, 0, 0, 1, 1, 0, 1, 16'h2000};
    rows[13] = '{1, 3, 16'h2002, 1, 1, 2, 1, 0, 1, 16'h2000};
    rows[14] = '{0, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000};
    rows[15] = '{1, 2, 16'h3000, 0, 0, 0, 1, 0, 0, 16'h0000};
    rows[16] = '{1, 0, 16'h3001, 0, 0, 1, 1, 0, 2, 16'h3000};
    rows[17] = '{1, 3, 16'h3002, 0, 0, 1, 1, 0, 2, 16'h3000};
    rows[18] = '{0, 1, 16'h0000, 1, 0, 2, 1, 1, 2, 16'h3000};
    rows[19] = '{0, 1, 16'h0000, 1, 0, 1, 1, 1, 3, 16'h3002};
    rows[20] = '{0, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000};

    a_rst = 1'b0; de_valid = 0; de_uops = '0; de_uop_count = '0; de_k = '0;
    ex_pc_w = 0; ex_feed_req = 0; irq = '0; int_restore = 0;
    mmask = 0; mvec = 0;
    #2;
    check("rst_level", q_level, 0);
    check("rst_ready", de_ready, 1);
    check("rst_ack", ex_feed_ack, 0);
    check("rst_count", ex_uop_count, 0);
    check("rst_irq_ack", irq_ack, 0);
    check("rst_irq_vec", irq_vec, 0);
    @(negedge clk); a_rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven push/pop/flush/count-0 sequences.
    foreach (rows[i]) begin
      de_valid     = rows[i].v;
      de_uop_count = CW'(rows[i].c);
      de_k         = rows[i].k;
      de_uops      = {$urandom, $urandom};
      ex_feed_req  = rows[i].req;
      ex_pc_w      = rows[i].pcw;
      tick_begin();
      check($sformatf("row%0d_level", i), q_level, rows[i].lvl);
      check($sformatf("row%0d_ready", i), de_ready, rows[i].rdy);
      check($sformatf("row%0d_ack", i), ex_feed_ack, rows[i].ack);
      check($sformatf("row%0d_count", i), ex_uop_count, rows[i].cnt);
      if (rows[i].cnt != 0) check($sformatf("row%0d_k", i), ex_k, rows[i].ek);
      tick_end();
    end
    de_valid = 0; ex_feed_req = 0; ex_pc_w = 0;

    // Interrupt: single pulse, hold while masked, restore wins, re-arbitrate after restore.
    irq = 4'b1010;
    tick_begin(); check("irq_first_ack", irq_ack, 4'b0010); tick_end();
    check("irq_vec_1", irq_vec, 1);
    tick_begin(); check("irq_held_noack", irq_ack, 4'b0000); tick_end();
    int_restore = 1;
    tick_begin(); check("irq_restore_noack", irq_ack, 4'b0000); tick_end();
    int_restore = 0;
    tick_begin(); check("irq_rearb_ack", irq_ack, 4'b0010); tick_end();
    irq = 4'b1111; int_restore = 1;
    tick_begin(); tick_end();
    int_restore = 0;
    tick_begin(); check("irq_prio0", irq_ack, 4'b0001); tick_end();
    check("irq_vec_0", irq_vec, 0);
    irq = 4'b1000; int_restore = 1;
    tick_begin(); tick_end();
    int_restore = 0;
    tick_begin(); check("irq_line3", irq_ack, 4'b1000); tick_end();
    check("irq_vec_3", irq_vec, 3);
    irq = '0; int_restore = 1;
    tick_begin(); tick_end();
    int_restore = 0;

    // Asynchronous reset mid-operation.
    de_valid = 1; de_uop_count = 2; de_k = 16'h4000; irq = 4'b0100;
    tick_begin(); tick_end();
    tick_begin(); tick_end();
    check("pre_rst_level", q_level, 2);
    de_valid = 0; irq = '0;
    a_rst = 1'b0;
    #1;
    check("async_rst_level", q_level, 0);
    check("async_rst_ready", de_ready, 1);
    check("async_rst_count", ex_uop_count, 0);
    check("async_rst_vec", irq_vec, 0);
    mq.delete(); mmask = 0; mvec = 0;
    @(negedge clk); a_rst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 10000; n++) begin
      de_valid     = ($urandom_range(9) < 7);
      de_uop_count = CW'($urandom_range(3));
      de_k         = KW'($urandom);
      de_uops      = {$urandom, $urandom};
      ex_feed_req  = ($urandom_range(1) == 1);
      ex_pc_w      = ($urandom_range(31) == 0);
      irq          = ($urandom_range(3) == 0) ? NI'($urandom) : '0;
      int_restore  = ($urandom_range(7) == 0);
      tick_begin();
      tick_end();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
